// File: rtl/attack_ctrl.sv
// attack_ctrl
// -----------
// Melee attack sequencer for a two-player sprite game. A button press in
// IDLE arms an attack that walks STARTUP -> ACTIVE -> RECOVERY -> IDLE, one
// step per video frame. While ACTIVE the hitbox (placed in front of the
// attacker) is tested against the opponent box. At most one hit lands per
// attack, and each hit adds HIT_DAMAGE to a saturating damage total.
//
// Ports
//   clk            pixel clock
//   rst            synchronous active-high reset
//   frame_rate     one-cycle pulse per video frame; all FSM moves happen here
//   button_attack  attack button level (1 = pressed)
//   x_pos, y_pos   attacker top-left, screen pixels
//   facing_right   attacker facing direction
//   opp_x, opp_y   opponent top-left, screen pixels
//   atk_state      registered FSM state: 0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY
//   hitbox_live    high while ACTIVE
//   hit_pulse      one-cycle pulse the cycle after a hit lands
//   knock_right    facing_right captured at the last hit
//   damage         opponent damage total, saturates at 999
//
// Handshake: there is no valid/ready pair here. frame_rate acts as a
// single-cycle qualifier: state, counter and hit evaluation only advance on
// cycles where it is 1; the button edge is captured on any cycle.
//
// Geometry is in screen pixels, with all source dimensions doubled, and is
// computed 11 bits wide so sums of 10-bit positions cannot wrap.

module attack_ctrl #(
  parameter int unsigned STARTUP_FRAMES  = 3,
  parameter int unsigned ACTIVE_FRAMES   = 4,
  parameter int unsigned RECOVERY_FRAMES = 8,
  parameter int unsigned HIT_DAMAGE      = 7,
  parameter int unsigned OWN_W           = 23,
  parameter int unsigned ATK_W           = 16,
  parameter int unsigned ATK_H           = 12,
  parameter int unsigned ATK_Y_OFF       = 10,
  parameter int unsigned OPP_W           = 30,
  parameter int unsigned OPP_H           = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_rate,
  input  logic       button_attack,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       facing_right,
  input  logic [9:0] opp_x,
  input  logic [9:0] opp_y,
  output logic [1:0] atk_state,
  output logic       hitbox_live,
  output logic       hit_pulse,
  output logic       knock_right,
  output logic [9:0] damage
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STARTUP  = 2'd1,
    S_ACTIVE   = 2'd2,
    S_RECOVERY = 2'd3
  } state_e;

  // Counter just wide enough for the longest phase.
  localparam int unsigned MAX_FR_A = (STARTUP_FRAMES > ACTIVE_FRAMES) ? STARTUP_FRAMES : ACTIVE_FRAMES;
  localparam int unsigned MAX_FR   = (MAX_FR_A > RECOVERY_FRAMES) ? MAX_FR_A : RECOVERY_FRAMES;
  localparam int unsigned CNT_W    = (MAX_FR < 2) ? 1 : $clog2(MAX_FR);

  localparam logic [CNT_W-1:0] STARTUP_LAST  = CNT_W'(STARTUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST   = CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] RECOVERY_LAST = CNT_W'(RECOVERY_FRAMES - 1);

  // Screen-space (2x) extents.
  localparam logic [10:0] OWN_DX  = 11'(2 * OWN_W);
  localparam logic [10:0] ATK_DX  = 11'(2 * ATK_W);
  localparam logic [10:0] ATK_DY  = 11'(2 * ATK_H);
  localparam logic [10:0] ATK_OFF = 11'(2 * ATK_Y_OFF);
  localparam logic [10:0] OPP_DX  = 11'(2 * OPP_W);
  localparam logic [10:0] OPP_DY  = 11'(2 * OPP_H);

  localparam logic [10:0] DMG_MAX = 11'd999;
  localparam logic [10:0] DMG_INC = 11'(HIT_DAMAGE);

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             hit_done_q, hit_done_d;
  logic             btn_q;
  logic             hit_pulse_q;
  logic             knock_q;
  logic [9:0]       damage_q, damage_d;

  // ---------------------------------------------------------------------
  // Button edge
  // ---------------------------------------------------------------------
  logic btn_edge;
  assign btn_edge = button_attack & ~btn_q;

  // ---------------------------------------------------------------------
  // Hitbox / opponent overlap
  // ---------------------------------------------------------------------
  logic [10:0] x11, y11, ox11, oy11;
  logic [10:0] hb_x0, hb_x1, hb_y0, hb_y1;
  logic [10:0] op_x0, op_x1, op_y0, op_y1;
  logic        overlap;

  assign x11  = {1'b0, x_pos};
  assign y11  = {1'b0, y_pos};
  assign ox11 = {1'b0, opp_x};
  assign oy11 = {1'b0, opp_y};

  always_comb begin
    if (facing_right) begin
      hb_x0 = x11 + OWN_DX;
      hb_x1 = x11 + OWN_DX + ATK_DX;
    end else begin
      // Hitbox sits to the left of the sprite; clamp at the screen edge.
      hb_x0 = (x11 >= ATK_DX) ? (x11 - ATK_DX) : 11'd0;
      hb_x1 = x11;
    end
  end

  assign hb_y0 = y11 + ATK_OFF;
  assign hb_y1 = y11 + ATK_OFF + ATK_DY;
  assign op_x0 = ox11;
  assign op_x1 = ox11 + OPP_DX;
  assign op_y0 = oy11;
  assign op_y1 = oy11 + OPP_DY;

  // Half-open intervals: edges that merely touch do not overlap.
  assign overlap = (hb_x0 < op_x1) && (op_x0 < hb_x1) &&
                   (hb_y0 < op_y1) && (op_y0 < hb_y1);

  // ---------------------------------------------------------------------
  // Damage saturation
  // ---------------------------------------------------------------------
  logic [10:0] dmg_sum;
  assign dmg_sum  = {1'b0, damage_q} + DMG_INC;
  assign damage_d = (dmg_sum > DMG_MAX) ? DMG_MAX[9:0] : dmg_sum[9:0];

  // ---------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------
  logic hit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    hit_done_d = hit_done_q;
    hit        = 1'b0;

    // Presses outside IDLE are dropped, not buffered.
    if (btn_edge && (state_q == S_IDLE)) begin
      pending_d = 1'b1;
    end

    if (frame_rate) begin
      unique case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            state_d    = S_STARTUP;
            pending_d  = 1'b0;
            cnt_d      = '0;
            hit_done_d = 1'b0;
          end
        end
        S_STARTUP: begin
          if (cnt_q == STARTUP_LAST) begin
            state_d = S_ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ACTIVE: begin
          // Evaluated on every ACTIVE tick, including the one that leaves.
          if (!hit_done_q && overlap) begin
            hit        = 1'b1;
            hit_done_d = 1'b1;
          end
          if (cnt_q == ACTIVE_LAST) begin
            state_d = S_RECOVERY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RECOVERY: begin
          if (cnt_q == RECOVERY_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // Tracking the live level during reset means a button held through
    // reset is not seen as a fresh press afterwards.
    btn_q <= button_attack;
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      hit_done_q  <= 1'b0;
      hit_pulse_q <= 1'b0;
      knock_q     <= 1'b0;
      damage_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      hit_done_q  <= hit_done_d;
      hit_pulse_q <= hit;
      if (hit) begin
        damage_q <= damage_d;
        knock_q  <= facing_right;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign atk_state   = state_q;
  assign hitbox_live = (state_q == S_ACTIVE);
  assign hit_pulse   = hit_pulse_q;
  assign knock_right = knock_q;
  assign damage      = damage_q;

endmodule

// File: tb/tb_attack_ctrl.sv
// tb_attack_ctrl
// --------------
// Directed bench for attack_ctrl with default parameters. Frames are one
// frame_rate pulse every four clocks. Outputs are read 1 time unit after
// the active edge; hit pulses are counted by a negedge monitor.

module tb_attack_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_rate;
  logic       button_attack;
  logic [9:0] x_pos, y_pos, opp_x, opp_y;
  logic       facing_right;
  logic [1:0] atk_state;
  logic       hitbox_live;
  logic       hit_pulse;
  logic       knock_right;
  logic [9:0] damage;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt  = 0;
  int long_pulse = 0;
  logic prev_pulse = 1'b0;

  logic [1:0] exp_q[$];

  attack_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_rate   (frame_rate),
    .button_attack(button_attack),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .facing_right (facing_right),
    .opp_x        (opp_x),
    .opp_y        (opp_y),
    .atk_state    (atk_state),
    .hitbox_live  (hitbox_live),
    .hit_pulse    (hit_pulse),
    .knock_right  (knock_right),
    .damage       (damage)
  );

  // ------------------------------------------------------------ clock
  always #5 clk = ~clk;

  // ------------------------------------------------------------ pulse monitor
  always @(negedge clk) begin
    if (hit_pulse === 1'b1) begin
      pulse_cnt++;
      if (prev_pulse) long_pulse++;
    end
    prev_pulse = (hit_pulse === 1'b1);
  end

  // ------------------------------------------------------------ checker
  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------ drivers
  task automatic tick_frame();
    @(posedge clk); #1 frame_rate = 1'b1;
    @(posedge clk); #1 frame_rate = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_frame();
  endtask

  task automatic press();
    @(posedge clk); #1 button_attack = 1'b1;
    repeat (2) @(posedge clk);
    #1 button_attack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_attack();
    press();
    ticks(16);
  endtask

  task automatic set_geom(input logic fr, input int x, input int y, input int ox, input int oy);
    facing_right = fr;
    x_pos = 10'(x);
    y_pos = 10'(y);
    opp_x = 10'(ox);
    opp_y = 10'(oy);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1 rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ------------------------------------------------------------ stimulus
  int p0;
  int exp_dmg;
  logic [1:0] e;

  initial begin
    rst = 1'b1;
    frame_rate = 1'b0;
    button_attack = 1'b0;
    set_geom(1'b1, 100, 200, 150, 210);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_eq("rst_state", atk_state, 0);
    check_eq("rst_live", hitbox_live, 0);
    check_eq("rst_pulse", hit_pulse, 0);
    check_eq("rst_knock", knock_right, 0);
    check_eq("rst_damage", damage, 0);

    // Full attack, facing right, overlapping opponent
    // hitbox x [146,178) y [220,244); opponent x [150,210) y [210,290)
    p0 = pulse_cnt;
    press();
    check_eq("t1_pre_state", atk_state, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back(2'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back(2'd2);
    for (int i = 0; i < 8; i++) exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    for (int i = 0; i < 16; i++) begin
      tick_frame();
      e = exp_q.pop_front();
      check_eq($sformatf("t1_state_%0d", i), atk_state, e);
      check_eq($sformatf("t1_live_%0d", i), hitbox_live, (e == 2'd2) ? 1 : 0);
    end
    check_eq("t1_pulses", pulse_cnt - p0, 1);
    check_eq("t1_damage", damage, 7);
    check_eq("t1_knock", knock_right, 1);

    // Edge touch: hitbox right edge 178 == opponent left edge
    set_geom(1'b1, 100, 200, 178, 210);
    p0 = pulse_cnt;
    run_attack();
    check_eq("touch_pulses", pulse_cnt - p0, 0);
    check_eq("touch_damage", damage, 7);
    check_eq("touch_state", atk_state, 0);

    // Press during RECOVERY is discarded; two presses in one frame give one attack
    set_geom(1'b1, 100, 200, 600, 210);
    press();
    ticks(8);
    check_eq("rec_state", atk_state, 3);
    press();
    ticks(8);
    check_eq("rec_back_idle", atk_state, 0);
    ticks(4);
    check_eq("rec_no_buffer", atk_state, 0);
    press();
    press();
    tick_frame();
    check_eq("dbl_started", atk_state, 1);
    ticks(15);
    check_eq("dbl_idle", atk_state, 0);
    ticks(3);
    check_eq("dbl_single", atk_state, 0);
    check_eq("dbl_damage", damage, 7);

    // Reset during ACTIVE on a frame tick that would land a hit
    set_geom(1'b1, 100, 200, 150, 210);
    p0 = pulse_cnt;
    press();
    ticks(4);
    check_eq("ra_active", atk_state, 2);
    @(posedge clk); #1 frame_rate = 1'b1; rst = 1'b1;
    @(posedge clk); #1 frame_rate = 1'b0; rst = 1'b0;
    check_eq("ra_state", atk_state, 0);
    check_eq("ra_live", hitbox_live, 0);
    check_eq("ra_pulse", hit_pulse, 0);
    check_eq("ra_knock", knock_right, 0);
    check_eq("ra_damage", damage, 0);
    ticks(3);
    check_eq("ra_no_hit", pulse_cnt - p0, 0);
    check_eq("ra_stay_idle", atk_state, 0);

    // Facing left near screen edge: hitbox x clamps to [0,10)
    set_geom(1'b0, 10, 200, 0, 210);
    p0 = pulse_cnt;
    run_attack();
    check_eq("left_pulses", pulse_cnt - p0, 1);
    check_eq("left_damage", damage, 7);
    check_eq("left_knock", knock_right, 0);

    // Button held through reset creates no press
    button_attack = 1'b1;
    do_reset(2);
    ticks(2);
    check_eq("held_idle", atk_state, 0);
    button_attack = 1'b0;
    ticks(1);
    check_eq("held_release", atk_state, 0);
    check_eq("held_damage", damage, 0);

    // Saturation: 142 hits reach 994, then two more clamp at 999
    set_geom(1'b1, 100, 200, 150, 210);
    p0 = pulse_cnt;
    exp_dmg = 0;
    for (int i = 0; i < 142; i++) begin
      run_attack();
      exp_dmg = (exp_dmg + 7 > 999) ? 999 : exp_dmg + 7;
    end
    check_eq("sat_preload", damage, exp_dmg);
    check_eq("sat_preload_const", damage, 994);
    run_attack();
    check_eq("sat_clamp", damage, 999);
    run_attack();
    check_eq("sat_hold", damage, 999);
    check_eq("sat_pulses", pulse_cnt - p0, 144);
    check_eq("pulse_width", long_pulse, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
